// File: rtl/pipe_lzc_pkg.sv
// Shared sizing helpers for the leading-zero-count / normalize datapath.
// pipe_lzc_core and pipe_norm_shift both derive their port widths from here.
package pipe_lzc_pkg;

  // Width needed to hold a count in 0..size inclusive.
  function automatic int lzc_out_size(input int size);
    return $clog2(size + 1);
  endfunction

  function automatic int norm_nstage(input int size, input int bps);
    return ($clog2(size) + bps - 1) / bps;
  endfunction

  function automatic int norm_latency(input int size, input int bps);
    return norm_nstage(size, bps) + 1;
  endfunction

endpackage

// File: rtl/norm_shift_stage.sv
// One registered shift stage of the normalizer: resolves one BPS-bit digit of
// the count (stage STAGE_IDX covers count bits [STAGE_IDX*BPS-1 : (STAGE_IDX-1)*BPS]).
module norm_shift_stage
  import pipe_lzc_pkg::*;
#(
  parameter int SIZE      = 64,
  parameter int BPS       = 2,
  parameter int STAGE_IDX = 1
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            ce,
  input  logic                            in_valid,
  input  logic [SIZE-1:0]                 din,
  input  logic [lzc_out_size(SIZE)-1:0]   cnt,
  input  logic                            zero,
  output logic                            out_valid,
  output logic [SIZE-1:0]                 dout,
  output logic [lzc_out_size(SIZE)-1:0]   out_cnt,
  output logic                            out_zero
);

  localparam int SHIFT_W = $clog2(SIZE);
  localparam int LO      = (STAGE_IDX - 1) * BPS;
  // The last stage may only own a partial digit when SHIFT_W is not a multiple of BPS.
  localparam int HI      = ((STAGE_IDX * BPS) < SHIFT_W ? (STAGE_IDX * BPS) : SHIFT_W) - 1;

  logic [SHIFT_W-1:0] amt;

  assign amt = SHIFT_W'(cnt[HI:LO]) << LO;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      dout      <= '0;
      out_cnt   <= '0;
      out_zero  <= 1'b0;
    end else if (ce) begin
      out_valid <= in_valid;
      // Bubbles are still shifted so the datapath stays deterministic.
      dout      <= zero ? '0 : (din << amt);
      out_cnt   <= cnt;
      out_zero  <= zero;
    end
  end

endmodule

// File: rtl/pipe_norm_shift.sv
// Pipelined normalizing left shifter: shifts din left by its leading-zero count
// so the MSB becomes 1, with the count delay-matched for exponent adjustment.
module pipe_norm_shift
  import pipe_lzc_pkg::*;
#(
  parameter int SIZE           = 64,
  parameter int CNT_SIZE       = lzc_out_size(SIZE),
  parameter int BITS_PER_STAGE = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                ce,
  input  logic                in_valid,
  input  logic [SIZE-1:0]     din,
  input  logic [CNT_SIZE-1:0] cnt,
  output logic                out_valid,
  output logic [SIZE-1:0]     dout,
  output logic [CNT_SIZE-1:0] out_cnt,
  output logic                out_zero,
  output logic                out_norm_err
);

  localparam int SHIFT_W = $clog2(SIZE);
  localparam int NSTAGE  = norm_nstage(SIZE, BITS_PER_STAGE);
  localparam logic [CNT_SIZE-1:0] SIZE_C = CNT_SIZE'(SIZE);

  logic                valid_p [NSTAGE+1];
  logic [SIZE-1:0]     data_p  [NSTAGE+1];
  logic [CNT_SIZE-1:0] cnt_p   [NSTAGE+1];
  logic                zero_p  [NSTAGE+1];

  // Stage 0: input register. Counts above SIZE are illegal and collapse to zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_p[0] <= 1'b0;
      data_p[0]  <= '0;
      cnt_p[0]   <= '0;
      zero_p[0]  <= 1'b0;
    end else if (ce) begin
      valid_p[0] <= in_valid;
      data_p[0]  <= din;
      cnt_p[0]   <= cnt;
      zero_p[0]  <= (cnt >= SIZE_C);
    end
  end

  for (genvar k = 0; k < NSTAGE; k++) begin : g_stage
    norm_shift_stage #(
      .SIZE      (SIZE),
      .BPS       (BITS_PER_STAGE),
      .STAGE_IDX (k + 1)
    ) u_stage (
      .clk       (clk),
      .rst       (rst),
      .ce        (ce),
      .in_valid  (valid_p[k]),
      .din       (data_p[k]),
      .cnt       (cnt_p[k]),
      .zero      (zero_p[k]),
      .out_valid (valid_p[k+1]),
      .dout      (data_p[k+1]),
      .out_cnt   (cnt_p[k+1]),
      .out_zero  (zero_p[k+1])
    );
  end

  assign out_valid = valid_p[NSTAGE];
  assign dout      = data_p[NSTAGE];
  assign out_cnt   = cnt_p[NSTAGE];
  assign out_zero  = zero_p[NSTAGE];

  // Qualified by out_valid so reset and bubbles never flag a bad count.
  assign out_norm_err = out_valid & ~out_zero & ~dout[SIZE-1];

endmodule

// File: tb/tb_pipe_norm_shift.sv
// Bench for pipe_norm_shift (SIZE=64, 2 bits/stage): directed vectors plus a
// random stream, checked against a latency-queue model of x << lzc(x).
module tb_pipe_norm_shift;
  import pipe_lzc_pkg::*;

  localparam int SIZE = 64;
  localparam int CW   = lzc_out_size(SIZE);
  localparam int LAT  = norm_latency(SIZE, 2);

  logic            clk = 1'b0;
  logic            rst;
  logic            ce;
  logic            in_valid;
  logic [SIZE-1:0] din;
  logic [CW-1:0]   cnt;
  logic            out_valid;
  logic [SIZE-1:0] dout;
  logic [CW-1:0]   out_cnt;
  logic            out_zero;
  logic            out_norm_err;

  int n_tests = 0;
  int n_fail  = 0;

  logic            mv [LAT];
  logic [SIZE-1:0] md [LAT];
  logic [CW-1:0]   mc [LAT];

  pipe_norm_shift #(.SIZE(SIZE), .BITS_PER_STAGE(2)) dut (
    .clk          (clk),
    .rst          (rst),
    .ce           (ce),
    .in_valid     (in_valid),
    .din          (din),
    .cnt          (cnt),
    .out_valid    (out_valid),
    .dout         (dout),
    .out_cnt      (out_cnt),
    .out_zero     (out_zero),
    .out_norm_err (out_norm_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [SIZE-1:0] obs, input logic [SIZE-1:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [SIZE-1:0] ref_norm(input logic [SIZE-1:0] d, input logic [CW-1:0] c);
    if (int'(c) >= SIZE) return '0;
    return d << c;
  endfunction

  function automatic logic [CW-1:0] ref_lzc(input logic [SIZE-1:0] x);
    for (int i = SIZE - 1; i >= 0; i--)
      if (x[i]) return CW'(SIZE - 1 - i);
    return CW'(SIZE);
  endfunction

  task automatic model_clear();
    for (int i = 0; i < LAT; i++) begin
      mv[i] = 1'b0;
      md[i] = '0;
      mc[i] = '0;
    end
  endtask

  task automatic check_out();
    logic [SIZE-1:0] e_d;
    logic            e_z;
    e_d = ref_norm(md[LAT-1], mc[LAT-1]);
    e_z = int'(mc[LAT-1]) >= SIZE;
    chk("valid", SIZE'(out_valid), SIZE'(mv[LAT-1]));
    chk("dout", dout, e_d);
    chk("out_cnt", SIZE'(out_cnt), SIZE'(mc[LAT-1]));
    chk("out_zero", SIZE'(out_zero), SIZE'(e_z));
    chk("norm_err", SIZE'(out_norm_err), SIZE'(mv[LAT-1] & ~e_z & ~e_d[SIZE-1]));
  endtask

  task automatic step(input logic c_e, input logic v, input logic [SIZE-1:0] d, input logic [CW-1:0] c);
    ce = c_e; in_valid = v; din = d; cnt = c;
    @(posedge clk);
    if (c_e) begin
      for (int i = LAT - 1; i > 0; i--) begin
        mv[i] = mv[i-1]; md[i] = md[i-1]; mc[i] = mc[i-1];
      end
      mv[0] = v; md[0] = d; mc[0] = c;
    end
    #1 check_out();
  endtask

  task automatic bubbles(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, '0, '0);
  endtask

  initial begin
    logic [SIZE-1:0] x;
    logic [1:0] ce_pat [7];
    rst = 1'b1; ce = 1'b0; in_valid = 1'b0; din = '0; cnt = '0;
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", SIZE'(out_valid), '0);
    chk("rst_dout", dout, '0);
    chk("rst_cnt", SIZE'(out_cnt), '0);
    chk("rst_zero", SIZE'(out_zero), '0);
    chk("rst_err", SIZE'(out_norm_err), '0);
    @(negedge clk) rst = 1'b0;

    // single set bit at LSB
    step(1'b1, 1'b1, 64'h1, CW'(63));
    bubbles(LAT - 1);
    chk("t1_dout", dout, 64'h8000_0000_0000_0000);
    chk("t1_cnt", SIZE'(out_cnt), 64'd63);
    chk("t1_zero", SIZE'(out_zero), '0);
    chk("t1_err", SIZE'(out_norm_err), '0);

    // cnt=0 passthrough, true zero, illegal count
    step(1'b1, 1'b1, 64'h8123_4567_89AB_CDEF, CW'(0));
    step(1'b1, 1'b1, 64'h0, CW'(64));
    step(1'b1, 1'b1, 64'h5, CW'(127));
    bubbles(1);
    chk("t2_pass", dout, 64'h8123_4567_89AB_CDEF);
    bubbles(1);
    chk("t2_zero_dout", dout, '0);
    chk("t2_zero_flag", SIZE'(out_zero), 64'd1);
    bubbles(1);
    chk("t2_ill_dout", dout, '0);
    chk("t2_ill_flag", SIZE'(out_zero), 64'd1);
    chk("t2_ill_cnt", SIZE'(out_cnt), 64'd127);
    bubbles(LAT);

    // back-to-back random stream with golden counts
    for (int i = 0; i < 1000; i++) begin
      x = {$urandom(), $urandom()} >> $urandom_range(0, SIZE - 1);
      if (x == '0) x = 64'h1;
      step(1'b1, 1'b1, x, ref_lzc(x));
      if (i >= LAT - 1) chk("t3_msb", SIZE'(dout[SIZE-1]), 64'd1);
    end
    bubbles(LAT);

    // ce stalls: only ce=1 cycles advance; ignored inputs are garbage
    ce_pat = '{2'd1, 2'd0, 2'd0, 2'd1, 2'd1, 2'd0, 2'd1};
    step(1'b1, 1'b1, 64'h0000_0100_0000_0000, CW'(23));
    for (int i = 1; i < 7; i++) begin
      x = {$urandom(), $urandom()};
      if (ce_pat[i] == 2'd1) step(1'b1, 1'b0, '0, '0);
      else step(1'b0, 1'b1, x, CW'($urandom_range(0, 127)));
    end
    chk("t4_valid", SIZE'(out_valid), 64'd1);
    chk("t4_dout", dout, 64'h8000_0000_0000_0000);
    bubbles(LAT);

    // async reset with operands in flight
    step(1'b1, 1'b1, 64'h1234, ref_lzc(64'h1234));
    step(1'b1, 1'b1, 64'h0F00, ref_lzc(64'h0F00));
    step(1'b1, 1'b1, 64'h0003, ref_lzc(64'h0003));
    ce = 1'b1; in_valid = 1'b0; din = '0; cnt = '0;
    #3 rst = 1'b1;
    #1;
    chk("t5_async_valid", SIZE'(out_valid), '0);
    chk("t5_async_dout", dout, '0);
    model_clear();
    @(posedge clk);
    @(negedge clk) rst = 1'b0;
    step(1'b1, 1'b1, 64'h0000_0000_00FF_0000, ref_lzc(64'h0000_0000_00FF_0000));
    for (int i = 0; i < LAT - 1; i++) begin
      chk("t5_no_stale", SIZE'(out_valid), '0);
      bubbles(1);
    end
    chk("t5_new_valid", SIZE'(out_valid), 64'd1);
    chk("t5_new_dout", dout, 64'hFF00_0000_0000_0000);
    bubbles(LAT);

    // count too small
    step(1'b1, 1'b1, 64'h0000_0000_0000_00F0, CW'(50));
    bubbles(LAT - 1);
    chk("t6_dout", dout, 64'h03C0_0000_0000_0000);
    chk("t6_err", SIZE'(out_norm_err), 64'd1);
    bubbles(2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
